migu_fetch: RTL and testbench

- Parametrised instruction-fetch front end for the Mig-U micro core, the next step beyond the bare core shell.
- Holds the fetch PC, starting from the reset address. Issues word-aligned requests to an in-order instruction memory port and buffers returned instructions in a FIFO toward decode.
- Supports redirect (branch/trap) with flush and discard of in-flight responses.

---
 rtl/migu_fetch.sv | 121 ++++++++++++
 tb/tb_migu_fetch.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/migu_fetch.sv
// migu_fetch: Mig-U fetch front end (credit-limited requests, in-order response FIFO, redirect flush).
// Define MIGU_FETCH_PERF_EN to add the perf_stall_cnt output.
module migu_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_SIZE = 4,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [ADDR_WIDTH-3:0] rst_addr,
  output logic req_valid,
  input  logic req_ready,
  output logic [ADDR_WIDTH-3:0] req_addr,
  input  logic rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic redirect_valid,
  input  logic [ADDR_WIDTH-3:0] redirect_addr,
  output logic insn_valid,
  input  logic insn_ready,
  output logic [31:0] insn_data,
  output logic [ADDR_WIDTH-3:0] insn_pc
`ifdef MIGU_FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int W = ADDR_WIDTH - 2;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEP = (CW + 1)'(DEPTH);

  if (INSN_SIZE != 4) begin : g_insn_size_check
    $error("migu_fetch: INSN_SIZE must be 4");
  end
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("migu_fetch: DEPTH must be a power of 2 in 2..16");
  end

  logic [W-1:0] pc;
  logic [CW-1:0] outstanding, drop, count, redir_cnt;
  logic [PW-1:0] rd_ptr, wr_ptr, q_head, q_tail;
  logic [31:0] fifo_data [DEPTH];
  logic [W-1:0] fifo_pc [DEPTH];
  logic [W-1:0] flight_pc [DEPTH];
  logic accept, keep, pop;

  // outstanding counts dropped requests too, so a FIFO slot always waits for every response
  assign req_valid = !rst && ({1'b0, outstanding} + {1'b0, count} < DEP);
  assign req_addr = pc;
  assign insn_valid = !rst && count != '0;
  assign insn_data = fifo_data[rd_ptr];
  assign insn_pc = fifo_pc[rd_ptr];
  assign accept = req_valid && req_ready;
  assign keep = rsp_valid && drop == '0;
  assign pop = insn_valid && insn_ready;
  assign redir_cnt = outstanding - CW'(rsp_valid) + CW'(accept);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= rst_addr;
      outstanding <= '0;
      drop <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      q_head <= '0;
      q_tail <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_addr;
      outstanding <= redir_cnt;
      drop <= redir_cnt;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      q_head <= '0;
      q_tail <= '0;
    end else begin
      pc <= accept ? pc + W'(1) : pc;
      outstanding <= outstanding + CW'(accept) - CW'(rsp_valid);
      drop <= drop - CW'(rsp_valid && drop != '0);
      count <= count + CW'(keep) - CW'(pop);
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(keep);
      q_head <= q_head + PW'(keep);
      q_tail <= q_tail + PW'(accept);
    end
  end

  // storage needs no reset: pointers and counts define which entries are live
  always_ff @(posedge clk) begin
    if (accept) flight_pc[q_tail] <= pc;
    if (keep) begin
      fifo_data[wr_ptr] <= rsp_data;
      fifo_pc[wr_ptr] <= flight_pc[q_head];
    end
  end

`ifdef MIGU_FETCH_PERF_EN
  logic redir_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      redir_q <= 1'b0;
      perf_stall_cnt <= '0;
    end else begin
      redir_q <= redirect_valid;
      if (!insn_valid && !redir_q && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rsp_valid && outstanding == '0))
        else $error("migu_fetch: response with no request outstanding");
      assert ({1'b0, outstanding} + {1'b0, count} <= DEP)
        else $error("migu_fetch: credit overflow");
      assert (drop <= outstanding)
        else $error("migu_fetch: drop exceeds outstanding");
    end
  end
endmodule

// File: tb/tb_migu_fetch.sv
// tb_migu_fetch: randomized self-checking bench for migu_fetch against a queue-based memory/decode model.
module tb_migu_fetch;
  localparam int DEPTH = 4;
  logic clk, rst, req_valid, req_ready, rsp_valid, redirect_valid, insn_valid, insn_ready;
  logic [29:0] rst_addr, req_addr, redirect_addr, insn_pc;
  logic [31:0] rsp_data, insn_data, seed;
`ifdef MIGU_FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  int m_stall;
  bit m_prev_redir;
`endif
  int n_chk, n_err, cyc, lat, n_acc, n_pop;
  logic [29:0] mpc;
  logic [29:0] q_pc[$];
  bit q_stale[$];
  int q_due[$];
  logic [29:0] fq[$];

  migu_fetch #(.ADDR_WIDTH(32), .INSN_SIZE(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rst_addr(rst_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_data(insn_data), .insn_pc(insn_pc)
`ifdef MIGU_FETCH_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [29:0] p);
    return {p[15:0], p[29:14]} ^ seed;
  endfunction

  // one clock cycle: drive memory, compare DUT outputs with the model, then advance the model
  task automatic step();
    logic e_rv, e_iv, acc, pop, r, s;
    logic [29:0] p;
    rsp_valid = !rst && q_pc.size() > 0 && q_due[0] <= cyc;
    rsp_data = rsp_valid ? data_of(q_pc[0]) : $urandom;
    #1;
    e_rv = !rst && (q_pc.size() + fq.size() < DEPTH);
    e_iv = !rst && fq.size() != 0;
    n_chk++;
    if (req_valid !== e_rv) begin
      n_err++;
      $display("FAIL model_req_valid cyc=%0d got=%b exp=%b", cyc, req_valid, e_rv);
    end
    if (e_rv) begin
      n_chk++;
      if (req_addr !== mpc) begin
        n_err++;
        $display("FAIL model_req_addr cyc=%0d got=%h exp=%h", cyc, req_addr, mpc);
      end
    end
    n_chk++;
    if (insn_valid !== e_iv) begin
      n_err++;
      $display("FAIL model_insn_valid cyc=%0d got=%b exp=%b", cyc, insn_valid, e_iv);
    end
    if (e_iv) begin
      n_chk++;
      if (insn_pc !== fq[0] || insn_data !== data_of(fq[0])) begin
        n_err++;
        $display("FAIL model_insn cyc=%0d got pc=%h data=%h exp pc=%h data=%h",
                 cyc, insn_pc, insn_data, fq[0], data_of(fq[0]));
      end
    end
`ifdef MIGU_FETCH_PERF_EN
    if (!rst) begin
      n_chk++;
      if (perf_stall_cnt !== m_stall) begin
        n_err++;
        $display("FAIL perf_stall_cnt cyc=%0d got=%0d exp=%0d", cyc, perf_stall_cnt, m_stall);
      end
    end
`endif
    acc = e_rv && req_ready;
    pop = e_iv && insn_ready;
    r = rsp_valid;
    @(posedge clk);
`ifdef MIGU_FETCH_PERF_EN
    if (rst) begin
      m_stall = 0;
      m_prev_redir = 0;
    end else begin
      if (!e_iv && !m_prev_redir) m_stall++;
      m_prev_redir = redirect_valid;
    end
`endif
    if (rst) begin
      q_pc.delete();
      q_stale.delete();
      q_due.delete();
      fq.delete();
      mpc = rst_addr;
    end else begin
      if (pop) begin
        p = fq.pop_front();
        n_pop++;
      end
      if (r) begin
        p = q_pc.pop_front();
        s = q_stale.pop_front();
        q_due.pop_front();
        if (!s) fq.push_back(p);
      end
      if (acc) begin
        q_pc.push_back(mpc);
        q_stale.push_back(1'b0);
        q_due.push_back(cyc + lat);
        n_acc++;
      end
      if (redirect_valid) begin
        foreach (q_stale[i]) q_stale[i] = 1'b1;
        fq.delete();
        mpc = redirect_addr;
      end else if (acc) mpc = mpc + 30'd1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [29:0] a);
    rst = 1'b1;
    rst_addr = a;
    redirect_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rst_addr = 30'h400;
    req_ready = 1'b1;
    insn_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    lat = 1;
    step();
    step();
    n_chk++;
    if (req_valid !== 1'b0 || insn_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs got req_valid=%b insn_valid=%b exp 0 0", req_valid, insn_valid);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (req_valid !== 1'b1 || req_addr !== 30'h400) begin
      n_err++;
      $display("FAIL reset_first_req got valid=%b addr=%h exp 1 400", req_valid, req_addr);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (req_valid !== 1'b1 || req_addr !== 30'(32'h400 + i)) begin
        n_err++;
        $display("FAIL stream_req i=%0d got valid=%b addr=%h exp addr=%h", i, req_valid, req_addr, 30'(32'h400 + i));
      end
      n_chk++;
      if (i < 2 ? insn_valid !== 1'b0 : (insn_valid !== 1'b1 || insn_pc !== 30'(32'h400 + i - 2))) begin
        n_err++;
        $display("FAIL stream_insn i=%0d got valid=%b pc=%h", i, insn_valid, insn_pc);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int a0;
    insn_ready = 1'b0;
    req_ready = 1'b1;
    lat = 1;
    do_reset(30'h400);
    a0 = n_acc;
    repeat (10) step();
    n_chk++;
    if (n_acc - a0 != 4 || req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_credits got accepts=%0d req_valid=%b exp 4 0", n_acc - a0, req_valid);
    end
    insn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (insn_valid !== 1'b1 || insn_pc !== 30'(32'h400 + i) || insn_data !== data_of(30'(32'h400 + i))) begin
        n_err++;
        $display("FAIL bp_drain i=%0d got valid=%b pc=%h data=%h", i, insn_valid, insn_pc, insn_data);
      end
      step();
    end
  endtask

  task automatic test_redirect_inflight();
    int k;
    req_ready = 1'b1;
    insn_ready = 1'b1;
    lat = 3;
    do_reset(30'h400);
    k = 0;
    while (q_pc.size() != 3 && k < 20) begin
      step();
      k++;
    end
    n_chk++;
    if (k >= 20) begin
      n_err++;
      $display("FAIL redir_setup got outstanding=%0d exp 3", q_pc.size());
    end
    redirect_valid = 1'b1;
    redirect_addr = 30'h80;
    step();
    redirect_valid = 1'b0;
    n_chk++;
    if (insn_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redir_flush got insn_valid=%b exp 0", insn_valid);
    end
    k = 0;
    while (insn_valid !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    n_chk++;
    if (insn_valid !== 1'b1 || insn_pc !== 30'h80 || insn_data !== data_of(30'h80)) begin
      n_err++;
      $display("FAIL redir_first got valid=%b pc=%h data=%h exp pc=80", insn_valid, insn_pc, insn_data);
    end
  endtask

  task automatic test_simultaneous();
    int k;
    lat = 1;
    req_ready = 1'b1;
    insn_ready = 1'b1;
    do_reset(30'h400);
    repeat (5) step();
    n_chk++;
    if (insn_valid !== 1'b1 || req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL simul_pre got insn_valid=%b req_valid=%b exp 1 1", insn_valid, req_valid);
    end
    redirect_valid = 1'b1;
    redirect_addr = 30'h200;
    step();
    redirect_valid = 1'b0;
    n_chk++;
    if (insn_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 30'h200) begin
      n_err++;
      $display("FAIL simul_after got insn_valid=%b req_valid=%b addr=%h exp 0 1 200", insn_valid, req_valid, req_addr);
    end
    k = 0;
    while (insn_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (insn_valid !== 1'b1 || insn_pc !== 30'(32'h200 + i)) begin
        n_err++;
        $display("FAIL simul_stream i=%0d got valid=%b pc=%h", i, insn_valid, insn_pc);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_addr = 30'h3FFFFFFF;
    step();
    redirect_valid = 1'b0;
    n_chk++;
    if (req_valid !== 1'b1 || req_addr !== 30'h3FFFFFFF) begin
      n_err++;
      $display("FAIL wrap_top got valid=%b addr=%h exp 1 3fffffff", req_valid, req_addr);
    end
    step();
    n_chk++;
    if (req_valid !== 1'b1 || req_addr !== 30'h0) begin
      n_err++;
      $display("FAIL wrap_zero got valid=%b addr=%h exp 1 0", req_valid, req_addr);
    end
    repeat (4) step();
  endtask

  task automatic test_reset_midstream();
    insn_ready = 1'b0;
    lat = 1;
    repeat (8) step();
    n_chk++;
    if (req_valid !== 1'b0 || insn_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_full got req_valid=%b insn_valid=%b exp 0 1", req_valid, insn_valid);
    end
    rst = 1'b1;
    rst_addr = 30'h123;
    #1;
    n_chk++;
    if (req_valid !== 1'b0 || insn_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_cycle got req_valid=%b insn_valid=%b exp 0 0", req_valid, insn_valid);
    end
    step();
    rst = 1'b0;
    #1;
    n_chk++;
    if (insn_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 30'h123) begin
      n_err++;
      $display("FAIL mid_restart got insn_valid=%b req_valid=%b addr=%h exp 0 1 123", insn_valid, req_valid, req_addr);
    end
`ifdef MIGU_FETCH_PERF_EN
    n_chk++;
    if (perf_stall_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL mid_perf got %0d exp 0", perf_stall_cnt);
    end
`endif
    insn_ready = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_random();
    int p0;
    do_reset(30'($urandom));
    p0 = n_pop;
    for (int i = 0; i < 800; i++) begin
      req_ready = $urandom_range(0, 3) != 0;
      insn_ready = $urandom_range(0, 9) < 7;
      lat = $urandom_range(1, 4);
      redirect_valid = $urandom_range(0, 24) == 0;
      redirect_addr = 30'($urandom);
      rst = $urandom_range(0, 299) == 0;
      if (rst) rst_addr = 30'($urandom);
      step();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    n_chk++;
    if (n_pop - p0 < 100) begin
      n_err++;
      $display("FAIL random_progress got pops=%0d exp >=100", n_pop - p0);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc = 0;
    n_acc = 0;
    n_pop = 0;
    mpc = '0;
    seed = $urandom;
    rsp_valid = 1'b0;
    rsp_data = '0;
`ifdef MIGU_FETCH_PERF_EN
    m_stall = 0;
    m_prev_redir = 0;
`endif
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_simultaneous();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
